// File: rtl/four_to_two_encoder_hs.sv
// Registered 4-to-2 priority encoder with sticky pending requests and a
// valid/ack output handshake; bit 3 is the highest priority.
module four_to_two_encoder_hs (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic ack,
  output logic a0,
  output logic a1,
  output logic valid,
  output logic more
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  pend_q, pend_d;
  logic [1:0]  idx_q, idx_d;
  logic        more_q, more_d;
  logic [3:0]  req, comb;
  logic [1:0]  pick;
  logic        load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      pend_q  <= 4'b0000;
      idx_q   <= 2'b00;
      more_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      more_q  <= more_d;
    end
  end

  always_comb begin
    req     = en ? {d3, d2, d1, d0} : 4'b0000;
    comb    = pend_q | req;
    load    = (state_q == EMPTY) || ack;
    pick    = 2'd0;
    if      (comb[3]) pick = 2'd3;
    else if (comb[2]) pick = 2'd2;
    else if (comb[1]) pick = 2'd1;

    state_d = state_q;
    idx_d   = idx_q;
    // While the output is held, new requests simply accumulate.
    pend_d  = comb;
    if (load) begin
      if (comb != 4'b0000) begin
        state_d = FULL;
        idx_d   = pick;
        pend_d  = comb & ~(4'b0001 << pick);
      end else begin
        state_d = EMPTY;
        pend_d  = 4'b0000;
      end
    end
    more_d  = |pend_d;
  end

  assign a0    = idx_q[0];
  assign a1    = idx_q[1];
  assign valid = (state_q == FULL);
  assign more  = more_q;

endmodule

// File: doc/four_to_two_encoder_hs.md
# four_to_two_encoder_hs

Registered 4-to-2 priority encoder with sticky request capture and a valid/ack output handshake. It is the encoding counterpart of the 2-to-4 decoder. Four request lines d0..d3 are collected into a pending register. The highest-priority pending request is presented as the 2-bit index {a1,a0} and held until the consumer acknowledges it. Typical use: interrupt/request concentration ahead of a decoder-driven select path.

## Interface
- No parameters. Width is fixed at 4 requests / 2-bit index.
- clk    input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- en     input  1  request enable. When en=0, d0..d3 are ignored; pending requests and the handshake still run.
- d0     input  1  request 0, lowest priority, level-sampled.
- d1     input  1  request 1.
- d2     input  1  request 2.
- d3     input  1  request 3, highest priority.
- ack    input  1  consumer accepts the current index. Ignored when valid=0.
- a0     output 1  index LSB, registered.
- a1     output 1  index MSB, registered. Index = 2*a1 + a0.
- valid  output 1  {a1,a0} holds a serviced request, registered.
- more   output 1  at least one request is still pending behind the output, registered.

## Operation
- Internal state:
  - pend[3:0]: sticky pending register.
  - Output register: a1, a0, valid, more.
- Each cycle:
  - req = en ? {d3,d2,d1,d0} : 4'b0000.
  - comb = pend | req.
- Load condition: load = !valid || ack.
- On load with comb != 0:
  - idx = highest set bit of comb (bit 3 has highest priority).
  - {a1,a0} <= idx; valid <= 1.
  - pend <= comb & ~(1<<idx).
- On load with comb == 0: valid <= 0; {a1,a0} hold their last value; pend <= 0.
- No load (valid=1, ack=0):
  - {a1,a0} and valid hold.
  - pend <= comb, so new requests accumulate.
- more <= |(next value of pend) every cycle.
- Two-state view:
  - EMPTY (valid=0) goes to FULL when comb != 0. Otherwise it stays EMPTY.
  - FULL (valid=1) stays FULL under ack=0.
  - FULL with ack=1 goes to FULL if comb != 0 (back-to-back reload, no bubble). Otherwise it goes to EMPTY.
- Requests are level-sampled. A request held high for several cycles re-sets its pend bit every cycle. It is therefore re-reported after being serviced. Requesters drop their line after their index is seen.
- A request arriving for the index currently on the output, before ack, sets its pend bit and is reported again later.
- Duplicate requests for an already-pending index merge into one pend bit. Requests are not counted.
- Reset (rst_n=0 at a rising edge), including mid-operation:
  - pend=0, a0=0, a1=0, valid=0, more=0.
  - Inputs are ignored during that cycle.
  - Any held index is discarded without ack.

## Timing
- Latency: a request sampled at edge k with the output free (valid=0 or ack=1) gives valid=1 with its index after edge k. This is 1 cycle and has no combinational path from d to a.
- The output is stable from the edge that sets valid until the edge where ack=1 is sampled.
- Throughput: one index per cycle when ack is held at 1 and requests are pending.
- A new higher-priority request arriving while the output is held does not pre-empt it. It is served at the next load.
- ack and a new request at the same edge: the new request competes in comb for that same load.
- Reset values of all outputs are 0, visible after the first rising edge with rst_n=0.

## Test plan
- Reset: rst_n=0 for 2 edges with d0..d3=1111 and en=1 -> a1=0, a0=0, valid=0, more=0. Then rst_n=1 with d=0000 -> valid stays 0.
- Single request: en=1, d2=1 for one cycle -> after that edge a1=1, a0=0, valid=1, more=0. Then ack=1 for one cycle -> valid=0.
- Priority and back-to-back: d3=d0=1 for one cycle -> index 3, more=1. Then ack=1 held -> next edge index 0, more=0. Next edge valid=0.
- Hold under no-ack: index 3 valid with ack=0, pulse d1 -> a1,a0 stay 1,1 and more=1. Raise ack -> index 1 appears on the next edge.
- Enable masking: en=0, d=1111 for 3 cycles -> valid=0, more=0. Then en=1 with d=0000 -> still idle.
- Mid-operation reset: index 2 valid, more=1 (pend holds 0). Assert rst_n=0 for one edge -> all outputs 0. Release with no requests -> valid stays 0; no stale pend bit emerges.
